// File: rtl/write_back_stage.sv
// Registered MEM/WB stage: captures one instruction per handshake, commits to the
// register file or a private register bank, and counts retired instructions.
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
module write_back_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int PRIV_N  = 4,
  parameter int CNT_W   = 16,
  parameter int PRIV_AW = $clog2(PRIV_N)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic               stall,
  input  logic               flush,
  input  logic               regWrite,
  input  logic               memOrReg,
  input  logic               dstOrPrivate,
  input  logic [ADDR_W-1:0]  regDstAddress,
  input  logic [DATA_W-1:0]  memData,
  input  logic [DATA_W-1:0]  aluData,
  output logic               rfWrEn,
  output logic [ADDR_W-1:0]  rfWrAddr,
  output logic [DATA_W-1:0]  outputRes,
  input  logic [PRIV_AW-1:0] privRdAddr,
  output logic [DATA_W-1:0]  privRdData,
  output logic [CNT_W-1:0]   retireCount,
  output logic               fwdValid,
  output logic [ADDR_W-1:0]  fwdAddr,
  output logic [DATA_W-1:0]  fwdData
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_or_reg_q, mem_or_reg_d;
  logic              dst_or_private_q, dst_or_private_d;
  logic [ADDR_W-1:0] reg_dst_address_q, reg_dst_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [DATA_W-1:0] priv_q [PRIV_N];
  logic [DATA_W-1:0] priv_d [PRIV_N];

  logic               capture;
  logic               commit_rf;
  logic               commit_priv;
  logic [PRIV_AW-1:0] priv_idx;
  logic [DATA_W-1:0]  result;

  assign inReady = ~stall;
  // Flush beats capture; the instruction already held in the stage still commits.
  assign capture = inValid & ~stall & ~flush;

  always_comb begin
    valid_d           = capture;
    reg_write_d       = reg_write_q;
    mem_or_reg_d      = mem_or_reg_q;
    dst_or_private_d  = dst_or_private_q;
    reg_dst_address_d = reg_dst_address_q;
    mem_data_d        = mem_data_q;
    alu_data_d        = alu_data_q;
    if (capture) begin
      reg_write_d       = regWrite;
      mem_or_reg_d      = memOrReg;
      dst_or_private_d  = dstOrPrivate;
      reg_dst_address_d = regDstAddress;
      mem_data_d        = memData;
      alu_data_d        = aluData;
    end
  end

  assign result      = mem_or_reg_q ? mem_data_q : alu_data_q;
  assign commit_rf   = valid_q & reg_write_q & ~dst_or_private_q;
  assign commit_priv = valid_q & reg_write_q & dst_or_private_q;
  assign priv_idx    = reg_dst_address_q[PRIV_AW-1:0];

  always_comb begin
    for (int i = 0; i < PRIV_N; i++) begin
      priv_d[i] = priv_q[i];
    end
    if (commit_priv) begin
      priv_d[priv_idx] = result;
    end
  end

  // Counter wraps naturally from all-ones back to zero.
  always_comb begin
    retire_d = retire_q;
    if (valid_q) begin
      retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q           <= 1'b0;
      reg_write_q       <= 1'b0;
      mem_or_reg_q      <= 1'b0;
      dst_or_private_q  <= 1'b0;
      reg_dst_address_q <= '0;
      mem_data_q        <= '0;
      alu_data_q        <= '0;
      retire_q          <= '0;
      for (int i = 0; i < PRIV_N; i++) begin
        priv_q[i] <= '0;
      end
    end else begin
      valid_q           <= valid_d;
      reg_write_q       <= reg_write_d;
      mem_or_reg_q      <= mem_or_reg_d;
      dst_or_private_q  <= dst_or_private_d;
      reg_dst_address_q <= reg_dst_address_d;
      mem_data_q        <= mem_data_d;
      alu_data_q        <= alu_data_d;
      retire_q          <= retire_d;
      for (int i = 0; i < PRIV_N; i++) begin
        priv_q[i] <= priv_d[i];
      end
    end
  end

  assign rfWrEn      = commit_rf;
  assign rfWrAddr    = reg_dst_address_q;
  assign outputRes   = result;
  assign retireCount = retire_q;

  // Write-through so a reader sees a pending private write in the same cycle.
  always_comb begin
    privRdData = priv_q[privRdAddr];
    if (commit_priv && (privRdAddr == priv_idx)) begin
      privRdData = result;
    end
  end

`ifdef WB_FWD_EN
  assign fwdValid = commit_rf;
  assign fwdAddr  = reg_dst_address_q;
  assign fwdData  = result;
`else
  assign fwdValid = 1'b0;
  assign fwdAddr  = '0;
  assign fwdData  = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: commit paths, stall, flush, reset and counter wrap.
// A second instance with CNT_W=4 exercises the retire counter wrap.
module tb_write_back_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, stall, flush, regWrite, memOrReg, dstOrPrivate;
  logic [3:0]  regDstAddress;
  logic [15:0] memData, aluData;
  logic [1:0]  privRdAddr;
  logic        inReady, rfWrEn, fwdValid;
  logic [3:0]  rfWrAddr, fwdAddr;
  logic [15:0] outputRes, privRdData, retireCount, fwdData;

  logic        inValid2;
  logic        inReady2, rfWrEn2, fwdValid2;
  logic [3:0]  rfWrAddr2, fwdAddr2, retireCount2;
  logic [15:0] outputRes2, privRdData2, fwdData2;

  int total = 0;
  int bad   = 0;
  bit fwdOn;

  always #5 clk = ~clk;

  write_back_stage dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .stall(stall),
    .flush(flush), .regWrite(regWrite), .memOrReg(memOrReg), .dstOrPrivate(dstOrPrivate),
    .regDstAddress(regDstAddress), .memData(memData), .aluData(aluData),
    .rfWrEn(rfWrEn), .rfWrAddr(rfWrAddr), .outputRes(outputRes),
    .privRdAddr(privRdAddr), .privRdData(privRdData), .retireCount(retireCount),
    .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData)
  );

  write_back_stage #(.CNT_W(4)) dutWrap (
    .clk(clk), .rstN(rstN), .inValid(inValid2), .inReady(inReady2), .stall(1'b0),
    .flush(1'b0), .regWrite(1'b1), .memOrReg(1'b0), .dstOrPrivate(1'b0),
    .regDstAddress(4'd1), .memData(16'h0), .aluData(16'h0042),
    .rfWrEn(rfWrEn2), .rfWrAddr(rfWrAddr2), .outputRes(outputRes2),
    .privRdAddr(2'd0), .privRdData(privRdData2), .retireCount(retireCount2),
    .fwdValid(fwdValid2), .fwdAddr(fwdAddr2), .fwdData(fwdData2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic mr, input logic dp,
                               input logic [3:0] addr, input logic [15:0] md, input logic [15:0] ad);
    inValid = v; regWrite = rw; memOrReg = mr; dstOrPrivate = dp;
    regDstAddress = addr; memData = md; aluData = ad;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
`ifdef WB_FWD_EN
    fwdOn = 1'b1;
`else
    fwdOn = 1'b0;
`endif
    rstN = 1'b0; stall = 1'b0; flush = 1'b0; privRdAddr = 2'd0; inValid2 = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);

    // Reset state
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst_inReady", inReady, 1);
    checkOutput("rst_rfWrEn", rfWrEn, 0);
    checkOutput("rst_outputRes", outputRes, 0);
    checkOutput("rst_retire", retireCount, 0);
    checkOutput("rst_fwdValid", fwdValid, 0);
    checkOutput("rst_privRd", privRdData, 0);

    // Register-file load commit
    applyStimulus(1, 1, 1, 0, 4'd5, 16'hBEEF, 16'h1234);
    @(negedge clk);
    checkOutput("ld_rfWrEn", rfWrEn, 1);
    checkOutput("ld_rfWrAddr", rfWrAddr, 5);
    checkOutput("ld_outputRes", outputRes, 16'hBEEF);
    checkOutput("ld_fwdValid", fwdValid, fwdOn ? 1 : 0);
    checkOutput("ld_fwdAddr", fwdAddr, fwdOn ? 5 : 0);
    checkOutput("ld_fwdData", fwdData, fwdOn ? 16'hBEEF : 16'h0);
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("ld_once", rfWrEn, 0);
    checkOutput("ld_retire", retireCount, 1);
    checkOutput("ld_hold", outputRes, 16'hBEEF);

    // Private bank write with same-cycle bypass
    privRdAddr = 2'd2;
    applyStimulus(1, 1, 0, 1, 4'd6, 16'h7777, 16'h00A5);
    @(negedge clk);
    checkOutput("pv_rfWrEn", rfWrEn, 0);
    checkOutput("pv_bypass", privRdData, 16'h00A5);
    checkOutput("pv_fwdValid", fwdValid, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("pv_stored", privRdData, 16'h00A5);
    checkOutput("pv_retire", retireCount, 2);
    privRdAddr = 2'd1;
    #1 checkOutput("pv_other", privRdData, 16'h0000);

    // Stall for three cycles, then release
    stall = 1'b1;
    applyStimulus(1, 1, 0, 0, 4'd3, 16'h0, 16'h1111);
    #1 checkOutput("st_inReady", inReady, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("st_rfWrEn", rfWrEn, 0);
      checkOutput("st_retire", retireCount, 2);
    end
    stall = 1'b0;
    @(negedge clk);
    checkOutput("st_commit", rfWrEn, 1);
    checkOutput("st_addr", rfWrAddr, 3);
    checkOutput("st_res", outputRes, 16'h1111);
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("st_single", rfWrEn, 0);
    checkOutput("st_retire2", retireCount, 3);

    // Flush wins over capture
    flush = 1'b1;
    applyStimulus(1, 1, 0, 0, 4'd9, 16'h0, 16'h2222);
    @(negedge clk);
    checkOutput("fl_rfWrEn", rfWrEn, 0);
    checkOutput("fl_res", outputRes, 16'h1111);
    flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("fl_retire", retireCount, 3);

    // Flush while an instruction is in the stage: that one still commits
    applyStimulus(1, 1, 0, 0, 4'd4, 16'h0, 16'h3333);
    @(negedge clk);
    flush = 1'b1;
    applyStimulus(1, 1, 0, 0, 4'd8, 16'h0, 16'h4444);
    checkOutput("fl_incommit", rfWrEn, 1);
    checkOutput("fl_inres", outputRes, 16'h3333);
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    checkOutput("fl_after", rfWrEn, 0);
    checkOutput("fl_retire2", retireCount, 4);

    // Retire counter wrap on the 4-bit instance
    inValid2 = 1'b1;
    repeat (15) @(negedge clk);
    inValid2 = 1'b0;
    @(negedge clk);
    checkOutput("wr_at15", retireCount2, 15);
    inValid2 = 1'b1;
    @(negedge clk);
    inValid2 = 1'b0;
    @(negedge clk);
    checkOutput("wr_zero", retireCount2, 0);

    // Reset during a private commit drops the write
    privRdAddr = 2'd1;
    applyStimulus(1, 1, 0, 1, 4'd5, 16'h0, 16'h00C3);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    checkOutput("rm_bypass", privRdData, 16'h00C3);
    rstN = 1'b0;
    #1;
    checkOutput("rm_rfWrEn", rfWrEn, 0);
    checkOutput("rm_privRd", privRdData, 0);
    checkOutput("rm_retire", retireCount, 0);
    checkOutput("rm_outputRes", outputRes, 0);
    @(negedge clk);
    rstN = 1'b1;
    privRdAddr = 2'd2;
    @(negedge clk);
    checkOutput("rm_privCleared", privRdData, 0);
    privRdAddr = 2'd1;
    #1 checkOutput("rm_noWrite", privRdData, 0);
    checkOutput("rm_inReady", inReady, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
